tx_stream: RTL
==============

# tx_stream

Transmit side of the 32-bit valid/ready word link; drives the `data`/`valid` pair consumed by the link receiver and samples its `ready`. Local logic pushes words into a small internal FIFO. The block then sends them one word per `valid` pulse and forces `valid` low for a programmable gap between words, because the receiver arms and disarms `ready` on `valid` edges. It also keeps a running count of transferred words for debug display.

## Interface
- `DATA_W`, 32, width of link and push data.
- `DEPTH`, 4, FIFO entries; power of 2, minimum 2.
- `GAP_CYC`, 2, cycles `valid` is held low after each transfer; minimum 1.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  DATA_W  word to enqueue.
- `in_push`  in  1  enqueue `in_data` at this edge.
- `in_full`  out  1  FIFO holds DEPTH words; registered.
- `overflow`  out  1  sticky flag: a push arrived while `in_full` was 1.
- `data`  out  DATA_W  link data; registered.
- `valid`  out  1  link valid; registered.
- `ready`  in  1  link ready from the receiver.
- `sent_count`  out  32  number of completed transfers.
- `busy`  out  1  combinational: state != IDLE or FIFO not empty.

## Operation
- **Reset (`rst_n`=0, immediate):**
  - state IDLE, FIFO empty (pointers and count cleared).
  - `valid`=0, `data`=0, `sent_count`=0, `in_full`=0, `overflow`=0, `busy`=0.
  - Reset mid-transfer discards the FIFO and the in-flight word; no completion is counted.
- **FIFO:**
  - count width is clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
  - A push with `in_full`=0 writes `in_data`.
  - A push with `in_full`=1 is dropped and sets `overflow`, even if a pop happens at the same edge.
  - A push and a pop at the same edge leave the count unchanged.
- **Transfer:** occurs at a rising edge where `valid`=1 and `ready`=1.
- **States:**
  - IDLE (`valid`=0): at an edge with the FIFO not empty, pop the head into `data`, set `valid`=1 and go to SEND. Otherwise stay.
  - SEND (`valid`=1, `data` frozen): at an edge with `ready`=1, set `valid`=0, increment `sent_count`, load the gap counter with GAP_CYC-1 and go to GAP. At an edge with `ready`=0, hold everything, with no timeout.
  - GAP (`valid`=0): at each edge, if the counter is not 0, decrement it.
    - If the counter is 0 and the FIFO is not empty, pop into `data`, set `valid`=1 and go to SEND.
    - If the counter is 0 and the FIFO is empty, go to IDLE.
- `data` keeps the last sent word while `valid`=0.
- `sent_count` wraps from 0xFFFFFFFF to 0.
- `ready` changing while in IDLE or GAP has no effect.

## Timing
- **Push latency:** a push into an empty FIFO in IDLE at edge E0 puts `valid` high after edge E0+1.
- **Transfer length:** if `ready` is already 1 when `valid` rises, the transfer is at the next edge and `valid` is high for exactly 1 cycle.
- **After transfer at edge Et:**
  - `valid` is low for exactly GAP_CYC cycles.
  - If words remain, `valid` rises again after edge Et+GAP_CYC.
  - `sent_count` shows the new value after Et.
- **Sustained rate** with `ready` always 1: one word per GAP_CYC+1 cycles.
- **Receiver paired with a negedge-armed `ready`:** `valid` rises after edge E and the transfer lands at edge E+1, giving the same rate.
- **`in_full` timing:**
  - rises after the edge that stores the DEPTH-th word.
  - falls after the edge of the pop.

## Test plan
- **Single word:** reset, push 0xA5A5_0001 with `ready` tied to 1 → `valid` high for 1 cycle with `data`=0xA5A5_0001, `sent_count`=1, `busy`=0 after GAP_CYC+1 further cycles.
- **Burst with gap:** push 4 words 1..4 back-to-back, `ready`=1, GAP_CYC=2 → four 1-cycle `valid` pulses 3 cycles apart, data order 1,2,3,4, `sent_count`=4.
- **Backpressure:** `ready`=0 for 10 cycles after `valid` rises, then 1 → `valid` and `data` are stable for all 10 cycles, exactly one transfer, `sent_count`=1.
- **Full/overflow:**
  - hold `ready`=0 and push 6 words (DEPTH=4) → `in_full`=1 after 5 pushes, since one word sits in `data` and 4 in the FIFO, and `overflow`=1 on the 6th.
  - release `ready` → exactly 5 words are delivered, in order.
- **Reset mid-send:** drop `rst_n` while `valid`=1 with 2 words queued → `valid`=0 and `data`=0 immediately, `sent_count`=0; after release, no `valid` appears without a new push.
- **Wrap:** force `sent_count` to 0xFFFFFFFF via a hierarchical deposit, complete one transfer → `sent_count`=0.

Source files
------------

// File: rtl/tx_stream.sv
// Transmit side of the valid/ready word link: a small FIFO feeds single-word
// valid pulses, each followed by a fixed low gap so the receiver can re-arm ready.
module tx_stream #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_push,
    output logic              in_full,
    output logic              overflow,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic [31:0]       sent_count,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_ZERO  = GW'(0);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              in_full_r;
    logic              overflow_r;
    state_t            state_r;
    logic [GW-1:0]     gap_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic [31:0]       sent_count_r;

    state_t            state_s;
    logic [GW-1:0]     gap_s;
    logic [DATA_W-1:0] data_s;
    logic              valid_s;
    logic              pop_s;
    logic              sent_inc_s;
    logic              push_ok_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     count_s;

    // A push while full is dropped even if a pop frees a slot at the same edge.
    assign push_ok_s    = in_push & ~in_full_r;
    assign fifo_empty_s = (count_r == CW'(0));

    // Next FIFO occupancy from accepted push and FSM pop.
    always_comb begin
        count_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            in_full_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r   <= count_s;
            in_full_r <= (count_s == CNT_FULL);
            if (in_push && in_full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Link FSM: next state, pop request and registered link outputs.
    always_comb begin
        state_s    = state_r;
        gap_s      = gap_r;
        data_s     = data_r;
        valid_s    = valid_r;
        pop_s      = 1'b0;
        sent_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    data_s  = mem_r[rd_ptr_r];
                    valid_s = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    valid_s = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (ready) begin
                    valid_s    = 1'b0;
                    sent_inc_s = 1'b1;
                    gap_s      = GAP_LOAD;
                    state_s    = ST_GAP;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_r != GAP_ZERO) begin
                    gap_s   = gap_r - GAP_ONE;
                    state_s = ST_GAP;
                end else if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    data_s  = mem_r[rd_ptr_r];
                    valid_s = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    valid_s = 1'b0;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, gap counter, link outputs and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gap_r        <= '0;
            data_r       <= '0;
            valid_r      <= 1'b0;
            sent_count_r <= '0;
        end else begin
            state_r <= state_s;
            gap_r   <= gap_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            if (sent_inc_s) begin
                sent_count_r <= sent_count_r + 32'd1;
            end
        end
    end

    assign in_full    = in_full_r;
    assign overflow   = overflow_r;
    assign data       = data_r;
    assign valid      = valid_r;
    assign sent_count = sent_count_r;
    assign busy       = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule
